div_fu_ctrl: RTL and testbench



---
 rtl/div_fu_ctrl.sv | 112 +++++++++++
 tb/tb_div_fu_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_fu_ctrl.sv
// Integer divide FU sequencer: operand extension, divider handshake,
// divide-by-zero fast path and CDB result broadcast.
module div_fu_ctrl #(
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_funct3,
  input  logic [31:0]       issue_rs1,
  input  logic [31:0]       issue_rs2,
  input  logic [ROB_W-1:0]  issue_rob_idx,
  input  logic [PREG_W-1:0] issue_pd,
  output logic              div_start,
  output logic [32:0]       div_a,
  output logic [32:0]       div_b,
  input  logic              div_complete,
  input  logic [32:0]       div_quotient,
  input  logic [32:0]       div_remainder,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [31:0]       cdb_data,
  output logic [ROB_W-1:0]  cdb_rob_idx,
  output logic [PREG_W-1:0] cdb_pd
);

  typedef enum logic [2:0] {IDLE, START, BUSY, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        first_q;
  logic        op_rem;
  logic        accept;
  logic        div_zero;
  logic        sgn;
  logic        capture;
  logic        complete_ok;
  logic [31:0] res_sel;
  logic        unused_bits;

  assign issue_ready = (state_q == IDLE);
  assign cdb_valid   = (state_q == DONE);
  assign accept      = issue_valid & issue_ready & ~flush;
  assign div_zero    = (issue_rs2 == '0);
  assign sgn         = ~issue_funct3[0];
  // The divider's completion is not trusted in the cycle right after start.
  assign complete_ok = div_complete & ~first_q;
  assign res_sel     = op_rem ? div_remainder[31:0] : div_quotient[31:0];
  assign unused_bits = ^{issue_funct3[2], div_quotient[32], div_remainder[32]};

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = div_zero ? DONE : START;
      START: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          div_start = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A flush coinciding with completion has nothing left to drain.
        if (complete_ok) begin
          state_d = flush ? IDLE : DONE;
          capture = ~flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (complete_ok) state_d = IDLE;
      DONE:  if (flush || cdb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == START);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rem      <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_pd      <= '0;
    end else if (accept) begin
      op_rem      <= issue_funct3[1];
      div_a       <= {sgn & issue_rs1[31], issue_rs1};
      div_b       <= {sgn & issue_rs2[31], issue_rs2};
      cdb_rob_idx <= issue_rob_idx;
      cdb_pd      <= issue_pd;
      if (div_zero) cdb_data <= issue_funct3[1] ? issue_rs1 : '1;
    end else if (capture) begin
      cdb_data <= res_sel;
    end
  end

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Directed bench for div_fu_ctrl with a bench-side divider responding
// after a programmable latency with hand-computed quotient/remainder.
module tb_div_fu_ctrl;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 6;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        issue_funct3;
  logic [31:0]       issue_rs1;
  logic [31:0]       issue_rs2;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic [PREG_W-1:0] issue_pd;
  logic              div_start;
  logic [32:0]       div_a;
  logic [32:0]       div_b;
  logic              div_complete;
  logic [32:0]       div_quotient;
  logic [32:0]       div_remainder;
  logic              cdb_valid;
  logic              cdb_ready;
  logic [31:0]       cdb_data;
  logic [ROB_W-1:0]  cdb_rob_idx;
  logic [PREG_W-1:0] cdb_pd;

  div_fu_ctrl #(.ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rob_idx(issue_rob_idx), .issue_pd(issue_pd),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_complete(div_complete), .div_quotient(div_quotient),
    .div_remainder(div_remainder),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data),
    .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_lat = 4;
  int          start_cnt = 0;
  int          hs_cnt = 0;
  logic [32:0] rsp_q = '0;
  logic [32:0] rsp_r = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (div_start === 1'b1) start_cnt++;
    if (cdb_valid === 1'b1 && cdb_ready === 1'b1) hs_cnt++;
  end

  // Divider model: completes n_lat cycles after the start cycle.
  initial begin
    div_complete  = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    forever begin
      @(negedge clk);
      if (div_start === 1'b1) begin
        repeat (n_lat) @(posedge clk);
        #1;
        div_complete  = 1'b1;
        div_quotient  = rsp_q;
        div_remainder = rsp_r;
        @(posedge clk);
        #1;
        div_complete  = 1'b0;
      end
    end
  end

  task automatic drive_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] pd);
    issue_valid   = 1'b1;
    issue_funct3  = f3;
    issue_rs1     = a;
    issue_rs2     = b;
    issue_rob_idx = rob;
    issue_pd      = pd;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [ROB_W-1:0] rob,
                        input logic [PREG_W-1:0] pd, input logic [32:0] q, input logic [32:0] r,
                        input logic [32:0] ea, input logic [32:0] eb, input logic [31:0] ed,
                        input int hold);
    int   cyc;
    int   s0;
    int   h0;
    logic stable;
    rsp_q = q;
    rsp_r = r;
    s0 = start_cnt;
    chk($sformatf("%s.ready", tag), issue_ready, 1);
    drive_issue(f3, a, b, rob, pd);
    step();
    issue_valid = 1'b0;
    cyc = 1;
    while (cdb_valid !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk($sformatf("%s.lat", tag), cyc, (b == 0) ? 1 : 2 + n_lat);
    chk($sformatf("%s.data", tag), cdb_data, ed);
    chk($sformatf("%s.rob", tag), cdb_rob_idx, rob);
    chk($sformatf("%s.pd", tag), cdb_pd, pd);
    chk($sformatf("%s.div_a", tag), div_a, ea);
    chk($sformatf("%s.div_b", tag), div_b, eb);
    chk($sformatf("%s.starts", tag), start_cnt - s0, (b == 0) ? 0 : 1);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (cdb_valid !== 1'b1 || cdb_data !== ed || cdb_rob_idx !== rob ||
          cdb_pd !== pd || issue_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk($sformatf("%s.hold", tag), stable, 1);
    h0 = hs_cnt;
    cdb_ready = 1'b1;
    step();
    cdb_ready = 1'b0;
    chk($sformatf("%s.hs", tag), hs_cnt - h0, 1);
    chk($sformatf("%s.valid_off", tag), cdb_valid, 0);
    chk($sformatf("%s.idle", tag), issue_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   s0;
    logic seen;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; cdb_ready = 1'b0;
    issue_funct3 = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rob_idx = '0; issue_pd = '0;
    step();
    step();
    chk("rst.ready", issue_ready, 1);
    chk("rst.start", div_start, 0);
    chk("rst.valid", cdb_valid, 0);
    chk("rst.div_a", div_a, 0);
    chk("rst.data", cdb_data, 0);
    rst = 1'b0;
    step();

    n_lat = 4;
    run_op("div_s",  3'b100, 32'h14, 32'hFFFFFFFD, 5'd3, 6'd17,
           33'h1FFFFFFFA, 33'h2, 33'h000000014, 33'h1FFFFFFFD, 32'hFFFFFFFA, 0);
    run_op("rem_s",  3'b110, 32'h14, 32'hFFFFFFFD, 5'd4, 6'd18,
           33'h1FFFFFFFA, 33'h2, 33'h000000014, 33'h1FFFFFFFD, 32'h00000002, 5);
    n_lat = 2;
    run_op("divu",   3'b101, 32'hFFFFFFFF, 32'h2, 5'd5, 6'd33,
           33'h07FFFFFFF, 33'h1, 33'h0FFFFFFFF, 33'h000000002, 32'h7FFFFFFF, 0);
    run_op("remu",   3'b111, 32'hFFFFFFFF, 32'h2, 5'd6, 6'd34,
           33'h07FFFFFFF, 33'h1, 33'h0FFFFFFFF, 33'h000000002, 32'h00000001, 0);
    run_op("div_z",  3'b100, 32'h7, 32'h0, 5'd7, 6'd1,
           33'h0, 33'h0, 33'h7, 33'h0, 32'hFFFFFFFF, 0);
    run_op("divu_z", 3'b101, 32'h7, 32'h0, 5'd8, 6'd2,
           33'h0, 33'h0, 33'h7, 33'h0, 32'hFFFFFFFF, 0);
    run_op("rem_z",  3'b110, 32'h7, 32'h0, 5'd9, 6'd3,
           33'h0, 33'h0, 33'h7, 33'h0, 32'h00000007, 0);
    run_op("remu_z", 3'b111, 32'h7, 32'h0, 5'd10, 6'd4,
           33'h0, 33'h0, 33'h7, 33'h0, 32'h00000007, 0);
    n_lat = 5;
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd31, 6'd63,
           33'h080000000, 33'h0, 33'h180000000, 33'h1FFFFFFFF, 32'h80000000, 0);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd30, 6'd62,
           33'h080000000, 33'h0, 33'h180000000, 33'h1FFFFFFFF, 32'h00000000, 0);

    // Flush two cycles after div_start; divider answers at start+6.
    n_lat = 6;
    rsp_q = 33'hE;
    rsp_r = 33'h2;
    s0 = start_cnt;
    drive_issue(3'b100, 32'd100, 32'd7, 5'd12, 6'd20);
    step();
    issue_valid = 1'b0;
    chk("fl.start", div_start, 1);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    cyc = 4;
    seen = cdb_valid;
    while (issue_ready !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
      if (cdb_valid === 1'b1) seen = 1'b1;
    end
    chk("fl.idle_cyc", cyc, 8);
    chk("fl.no_valid", seen, 0);
    chk("fl.starts", start_cnt - s0, 1);
    n_lat = 3;
    run_op("fl.next", 3'b100, 32'd100, 32'd7, 5'd13, 6'd21,
           33'hE, 33'h2, 33'h64, 33'h7, 32'h0000000E, 0);

    // Asynchronous reset in the middle of BUSY.
    n_lat = 10;
    drive_issue(3'b111, 32'h55, 32'h10, 5'd14, 6'd22);
    step();
    issue_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst.ready", issue_ready, 1);
    chk("mrst.start", div_start, 0);
    chk("mrst.div_a", div_a, 0);
    chk("mrst.div_b", div_b, 0);
    chk("mrst.valid", cdb_valid, 0);
    chk("mrst.data", cdb_data, 0);
    chk("mrst.rob", cdb_rob_idx, 0);
    chk("mrst.pd", cdb_pd, 0);
    step();
    rst = 1'b0;
    repeat (15) step();
    chk("mrst.after", issue_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
